vending_controller: RTL and testbench
=====================================

Name: vending_controller

Overview:
- Synchronous, parametrised successor to the nine-button vending machine: one clock, configurable slot count, per-slot price and stock registers, credit accumulation with over-limit coin rejection, and a change-dispense state machine that pays out quarters, dimes and nickels one at a time over a ready/valid handshake.
- Sits between the debounced button/coin-acceptor front end and the 7-segment/LED display logic.
- Drives per-slot buyable and out-of-stock flags plus a display value.

Parameters:
- NUM_SLOTS, 9, number of selectable items.
- IDX_W, 4, width of slot index (must satisfy 2^IDX_W >= NUM_SLOTS).
- PRICE_W, 10, width of price/credit/change values in cents.
- STOCK_W, 4, width of per-slot stock counter.
- MAX_CREDIT, 500, highest credit accepted in cents (must be < 2^PRICE_W and a multiple of 5).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- coin_valid  in  1  one-cycle pulse, coin/bill inserted
- coin_sel  in  3  0=5c, 1=10c, 2=25c, 3=50c, 4=100c, 5=500c, 6-7 invalid
- sel_valid  in  1  one-cycle pulse, item button pressed
- sel_idx  in  IDX_W  selected slot
- cancel  in  1  one-cycle pulse, cancel/refund
- cfg_we  in  1  write price and stock of cfg_idx
- cfg_idx  in  IDX_W  slot being configured
- cfg_price  in  PRICE_W  new price; 0 disables the slot
- cfg_stock  in  STOCK_W  new stock count
- coin_out_ready  in  1  dispenser accepted current coin
- coin_out_valid  out  1  change coin pending
- coin_out_type  out  2  0=5c, 1=10c, 2=25c
- coin_reject  out  1  one-cycle pulse, inserted coin returned
- vend_valid  out  1  one-cycle pulse, release item
- vend_idx  out  IDX_W  slot released
- sel_error  out  1  one-cycle pulse: slot out of range, disabled, empty, or underfunded
- credit  out  PRICE_W  current credit
- can_buy  out  NUM_SLOTS  bit i = price[i]!=0 and stock[i]!=0 and credit>=price[i]
- oos  out  NUM_SLOTS  bit i = price[i]==0 or stock[i]==0
- disp_value  out  PRICE_W  value for 7-segment display
- busy  out  1  high in CHANGE state

Behaviour:
- Reset (async): state IDLE; credit, change remainder, disp_value, all prices and stocks = 0; every pulse output and coin_out_valid = 0; busy = 0; hence oos all 1 and can_buy all 0.
- States: IDLE and CHANGE.
- IDLE, same-cycle priority: cancel > sel_valid > coin_valid.
  - A lower-priority coin that loses to cancel or sel_valid is rejected.
  - A lower-priority sel that loses to cancel is ignored.
- cancel:
  - credit > 0: remainder <= credit, credit <= 0, go to CHANGE.
  - credit = 0: no effect.
- coin_valid:
  - coin_sel invalid, or credit + value > MAX_CREDIT: coin_reject = 1 next cycle; credit unchanged.
  - Otherwise credit <= credit + value.
  - The sum is computed at PRICE_W+1 bits, so it cannot wrap.
- sel_valid:
  - sel_idx >= NUM_SLOTS, price 0, or stock 0: sel_error pulse.
  - credit = 0: disp_value <= price[sel_idx] (price check); no sel_error.
  - 0 < credit < price: sel_error pulse; disp_value <= price.
  - Otherwise:
    - vend_valid = 1 and vend_idx = sel_idx on the next cycle.
    - stock[sel_idx] decrements.
    - remainder <= credit - price; credit <= 0.
    - Go to CHANGE if remainder > 0, else stay in IDLE.
- disp_value in IDLE: follows credit on each credit change; holds the price after a price check until the next coin or cancel.
- cfg_we: accepted only in IDLE with credit = 0 and cfg_idx < NUM_SLOTS; otherwise ignored.
- CHANGE:
  - busy = 1; disp_value = remainder.
  - coin_out_valid asserts the cycle after entry.
  - coin_out_type = largest of 25/10/5 that is <= remainder, and is stable while valid and not ready.
  - On valid and ready: remainder -= coin value.
  - Remainder reaching 0: coin_out_valid drops the same edge; return to IDLE with disp_value = 0.
- In CHANGE:
  - coin_valid produces coin_reject.
  - sel_valid and cancel are ignored.
  - cfg_we is ignored.
- Remainder is always a multiple of 5 because all accepted values are multiples of 5.
- Reset mid-dispense abandons the remainder; no coin is emitted after reset.

Test Plan:
- Config slot 0 to 125c/stock 2. Insert 100c + 50c -> credit 150, can_buy[0]=1. Select 0 -> vend_valid, vend_idx=0, stock 1, then one 25c coin handshake, busy drops, credit 0.
- credit 475, insert 50c -> coin_reject pulse, credit stays 475. Insert 25c -> credit 500. Insert 5c -> reject.
- credit 0, select slot price 325 -> disp_value=325, no vend, no sel_error. Insert 100, select -> sel_error, disp_value=325.
- Slot stock 1, vend it -> oos bit set. Credit 200, select again -> sel_error, credit stays 200. Cancel -> change 25,25,25,25,25,25,25,25 (eight coins) with random ready stalls, coin_out_type stable across stalls.
- Change 40c -> coins 25,10,5. Coin inserted during CHANGE -> coin_reject. Assert reset after the second coin -> all outputs at reset values, no third coin.
- Same cycle cancel+sel+coin with credit 100 -> refund 100 (four 25c), coin rejected, no vend.

Source files
------------

// File: rtl/vending_controller.sv
// Vending machine controller. Holds per-slot price and stock, accumulates
// credit with over-limit coin rejection, vends on selection and pays change
// out one coin at a time over a ready/valid handshake.
//
//   state  | meaning
//   IDLE   | accepting coins, selections, cancel and configuration writes
//   CHANGE | paying out the remainder, largest coin first; busy asserted
module vending_controller #(
    parameter int NUM_SLOTS  = 9,
    parameter int IDX_W      = 4,
    parameter int PRICE_W    = 10,
    parameter int STOCK_W    = 4,
    parameter int MAX_CREDIT = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coin_valid,
    input  logic [2:0]           coin_sel,
    input  logic                 sel_valid,
    input  logic [IDX_W-1:0]     sel_idx,
    input  logic                 cancel,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [PRICE_W-1:0]   cfg_price,
    input  logic [STOCK_W-1:0]   cfg_stock,
    input  logic                 coin_out_ready,
    output logic                 coin_out_valid,
    output logic [1:0]           coin_out_type,
    output logic                 coin_reject,
    output logic                 vend_valid,
    output logic [IDX_W-1:0]     vend_idx,
    output logic                 sel_error,
    output logic [PRICE_W-1:0]   credit,
    output logic [NUM_SLOTS-1:0] can_buy,
    output logic [NUM_SLOTS-1:0] oos,
    output logic [PRICE_W-1:0]   disp_value,
    output logic                 busy
);

    typedef enum logic {IDLE = 1'b0, CHANGE = 1'b1} state_t;

    localparam logic [PRICE_W:0] MAX_CREDIT_W = (PRICE_W+1)'(MAX_CREDIT);

    state_t             state;
    logic [PRICE_W-1:0] creditQ;
    logic [PRICE_W-1:0] remainderQ;
    logic [PRICE_W-1:0] dispQ;
    logic [PRICE_W-1:0] priceQ [NUM_SLOTS];
    logic [STOCK_W-1:0] stockQ [NUM_SLOTS];

    logic [PRICE_W:0]   coinValue;
    logic               coinLegal;
    logic [PRICE_W:0]   creditSum;
    logic               coinAccept;
    logic [PRICE_W-1:0] selPrice;
    logic [STOCK_W-1:0] selStock;
    logic               selInRange;
    logic               selOk;
    logic [PRICE_W-1:0] vendChange;
    logic [PRICE_W-1:0] changeNext;

    // Largest payable coin not exceeding the amount still owed.
    function automatic logic [1:0] pickCoin(input logic [PRICE_W-1:0] amount);
        if (amount >= PRICE_W'(25))      return 2'd2;
        else if (amount >= PRICE_W'(10)) return 2'd1;
        else                             return 2'd0;
    endfunction

    function automatic logic [PRICE_W-1:0] coinWorth(input logic [1:0] kind);
        case (kind)
            2'd2:    return PRICE_W'(25);
            2'd1:    return PRICE_W'(10);
            default: return PRICE_W'(5);
        endcase
    endfunction

    // Coin decode and limit check; one extra bit so the sum never wraps.
    always_comb begin
        coinValue = '0;
        coinLegal = 1'b1;
        case (coin_sel)
            3'd0:    coinValue = (PRICE_W+1)'(5);
            3'd1:    coinValue = (PRICE_W+1)'(10);
            3'd2:    coinValue = (PRICE_W+1)'(25);
            3'd3:    coinValue = (PRICE_W+1)'(50);
            3'd4:    coinValue = (PRICE_W+1)'(100);
            3'd5:    coinValue = (PRICE_W+1)'(500);
            default: coinLegal = 1'b0;
        endcase
        creditSum  = {1'b0, creditQ} + coinValue;
        coinAccept = coinLegal && (creditSum <= MAX_CREDIT_W);
    end

    // Selected-slot lookup; an out-of-range index reads as a disabled slot.
    always_comb begin
        selPrice   = '0;
        selStock   = '0;
        selInRange = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                selPrice   = priceQ[i];
                selStock   = stockQ[i];
                selInRange = 1'b1;
            end
        end
        selOk      = selInRange && (selPrice != '0) && (selStock != '0);
        vendChange = creditQ - selPrice;
        changeNext = remainderQ - coinWorth(coin_out_type);
    end

    // Per-slot status flags for the LED front panel.
    always_comb begin
        can_buy = '0;
        oos     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            oos[i]     = (priceQ[i] == '0) || (stockQ[i] == '0);
            can_buy[i] = !oos[i] && (creditQ >= priceQ[i]);
        end
    end

    // Main controller: credit, vend, configuration and change payout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            creditQ        <= '0;
            remainderQ     <= '0;
            dispQ          <= '0;
            coin_out_valid <= 1'b0;
            coin_out_type  <= 2'd0;
            coin_reject    <= 1'b0;
            vend_valid     <= 1'b0;
            vend_idx       <= '0;
            sel_error      <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                priceQ[i] <= '0;
                stockQ[i] <= '0;
            end
        end else begin
            coin_reject <= 1'b0;
            vend_valid  <= 1'b0;
            sel_error   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cancel) begin
                        coin_reject <= coin_valid;
                        if (creditQ != '0) begin
                            remainderQ <= creditQ;
                            dispQ      <= creditQ;
                            creditQ    <= '0;
                            state      <= CHANGE;
                        end
                    end else if (sel_valid) begin
                        coin_reject <= coin_valid;
                        if (!selOk) begin
                            sel_error <= 1'b1;
                        end else if (creditQ == '0) begin
                            dispQ <= selPrice;
                        end else if (creditQ < selPrice) begin
                            sel_error <= 1'b1;
                            dispQ     <= selPrice;
                        end else begin
                            vend_valid <= 1'b1;
                            vend_idx   <= sel_idx;
                            for (int i = 0; i < NUM_SLOTS; i++) begin
                                if (sel_idx == IDX_W'(i))
                                    stockQ[i] <= stockQ[i] - STOCK_W'(1);
                            end
                            remainderQ <= vendChange;
                            dispQ      <= vendChange;
                            creditQ    <= '0;
                            if (vendChange != '0)
                                state <= CHANGE;
                        end
                    end else if (coin_valid) begin
                        if (coinAccept) begin
                            creditQ <= creditSum[PRICE_W-1:0];
                            dispQ   <= creditSum[PRICE_W-1:0];
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                    // Reconfiguration only with no money in the machine.
                    if (cfg_we && (creditQ == '0)) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (cfg_idx == IDX_W'(i)) begin
                                priceQ[i] <= cfg_price;
                                stockQ[i] <= cfg_stock;
                            end
                        end
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_valid;
                    if (!coin_out_valid) begin
                        coin_out_valid <= 1'b1;
                        coin_out_type  <= pickCoin(remainderQ);
                    end else if (coin_out_ready) begin
                        remainderQ <= changeNext;
                        dispQ      <= changeNext;
                        if (changeNext == '0) begin
                            coin_out_valid <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            coin_out_type <= pickCoin(changeNext);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign credit     = creditQ;
    assign disp_value = dispQ;
    assign busy       = (state == CHANGE);

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller: configuration, credit limits,
// price checks, vending, change payout with stalls, reset mid-payout and
// same-cycle priority.
module tb_vending_controller;

    localparam int NUM_SLOTS = 9;
    localparam int IDX_W     = 4;
    localparam int PRICE_W   = 10;
    localparam int STOCK_W   = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 coin_valid = 1'b0;
    logic [2:0]           coin_sel = '0;
    logic                 sel_valid = 1'b0;
    logic [IDX_W-1:0]     sel_idx = '0;
    logic                 cancel = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [IDX_W-1:0]     cfg_idx = '0;
    logic [PRICE_W-1:0]   cfg_price = '0;
    logic [STOCK_W-1:0]   cfg_stock = '0;
    logic                 coin_out_ready = 1'b0;
    logic                 coin_out_valid;
    logic [1:0]           coin_out_type;
    logic                 coin_reject;
    logic                 vend_valid;
    logic [IDX_W-1:0]     vend_idx;
    logic                 sel_error;
    logic [PRICE_W-1:0]   credit;
    logic [NUM_SLOTS-1:0] can_buy;
    logic [NUM_SLOTS-1:0] oos;
    logic [PRICE_W-1:0]   disp_value;
    logic                 busy;

    int vectors = 0;
    int miscompares = 0;

    vending_controller dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_sel(coin_sel),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
        .coin_out_ready(coin_out_ready), .coin_out_valid(coin_out_valid),
        .coin_out_type(coin_out_type), .coin_reject(coin_reject),
        .vend_valid(vend_valid), .vend_idx(vend_idx), .sel_error(sel_error),
        .credit(credit), .can_buy(can_buy), .oos(oos),
        .disp_value(disp_value), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int idx, input int price, input int stock);
        cfg_we = 1'b1;
        cfg_idx = IDX_W'(idx);
        cfg_price = PRICE_W'(price);
        cfg_stock = STOCK_W'(stock);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic insertCoin(input int code);
        coin_valid = 1'b1;
        coin_sel = 3'(code);
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic selectSlot(input int idx);
        sel_valid = 1'b1;
        sel_idx = IDX_W'(idx);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic doCancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    // Wait (bounded) for a pending change coin, hold it for some stall
    // cycles checking it stays put, then accept it.
    task automatic takeCoin(input int expType, input int stalls, input string tag);
        int waitCnt = 0;
        while (!coin_out_valid && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        chk({tag, " valid"}, 32'(coin_out_valid), 1);
        chk({tag, " type"}, 32'(coin_out_type), expType);
        for (int s = 0; s < stalls; s++) begin
            tick();
            chk({tag, " stall valid"}, 32'(coin_out_valid), 1);
            chk({tag, " stall type"}, 32'(coin_out_type), expType);
        end
        coin_out_ready = 1'b1;
        tick();
        coin_out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        chk("rst credit", 32'(credit), 0);
        chk("rst oos", 32'(oos), 'h1FF);
        chk("rst can_buy", 32'(can_buy), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst coin_out_valid", 32'(coin_out_valid), 0);
        chk("rst disp", 32'(disp_value), 0);
        tick();
        reset = 1'b0;
        tick();

        // Configure slots 0..3
        cfg(0, 125, 2);
        cfg(1, 325, 3);
        cfg(2, 150, 1);
        cfg(3, 60, 5);
        chk("cfg oos", 32'(oos), 'h1F0);
        cfg(9, 5, 5);
        chk("cfg out of range", 32'(oos), 'h1F0);

        // Basic purchase with 25c change
        insertCoin(4);
        chk("credit 100", 32'(credit), 100);
        chk("can_buy at 100", 32'(can_buy), 'h008);
        insertCoin(3);
        chk("credit 150", 32'(credit), 150);
        chk("can_buy at 150", 32'(can_buy), 'h00D);
        selectSlot(0);
        chk("vend0 valid", 32'(vend_valid), 1);
        chk("vend0 idx", 32'(vend_idx), 0);
        chk("vend0 credit", 32'(credit), 0);
        chk("vend0 busy", 32'(busy), 1);
        chk("vend0 coin not yet", 32'(coin_out_valid), 0);
        chk("vend0 disp", 32'(disp_value), 25);
        takeCoin(2, 0, "chg25");
        chk("chg25 done busy", 32'(busy), 0);
        chk("chg25 done valid", 32'(coin_out_valid), 0);
        chk("chg25 done disp", 32'(disp_value), 0);
        chk("vend pulse dropped", 32'(vend_valid), 0);
        chk("slot0 still stocked", 32'(oos), 'h1F0);

        // Credit limit
        for (int k = 0; k < 4; k++) insertCoin(4);
        insertCoin(3);
        insertCoin(2);
        chk("credit 475", 32'(credit), 475);
        insertCoin(3);
        chk("reject 50 over limit", 32'(coin_reject), 1);
        chk("credit held 475", 32'(credit), 475);
        insertCoin(2);
        chk("credit 500", 32'(credit), 500);
        chk("reject pulse dropped", 32'(coin_reject), 0);
        insertCoin(0);
        chk("reject 5 over limit", 32'(coin_reject), 1);
        chk("credit held 500", 32'(credit), 500);
        insertCoin(6);
        chk("reject invalid coin", 32'(coin_reject), 1);
        doCancel();
        chk("cancel500 busy", 32'(busy), 1);
        chk("cancel500 credit", 32'(credit), 0);
        chk("cancel500 disp", 32'(disp_value), 500);
        for (int k = 0; k < 20; k++) takeCoin(2, 0, "drain500");
        chk("drain500 busy", 32'(busy), 0);

        // Price check and underfunded selection
        selectSlot(1);
        chk("pcheck disp", 32'(disp_value), 325);
        chk("pcheck sel_error", 32'(sel_error), 0);
        chk("pcheck vend", 32'(vend_valid), 0);
        insertCoin(4);
        chk("after pcheck disp", 32'(disp_value), 100);
        selectSlot(1);
        chk("underfund sel_error", 32'(sel_error), 1);
        chk("underfund disp", 32'(disp_value), 325);
        chk("underfund credit", 32'(credit), 100);

        // Vend the last item of slot 2, then retry it empty
        insertCoin(3);
        chk("sel_error pulse dropped", 32'(sel_error), 0);
        selectSlot(2);
        chk("vend2 valid", 32'(vend_valid), 1);
        chk("vend2 idx", 32'(vend_idx), 2);
        chk("vend2 no change busy", 32'(busy), 0);
        chk("vend2 oos", 32'(oos), 'h1F4);
        insertCoin(4);
        insertCoin(4);
        chk("credit 200", 32'(credit), 200);
        selectSlot(2);
        chk("empty sel_error", 32'(sel_error), 1);
        chk("empty credit held", 32'(credit), 200);
        chk("empty no vend", 32'(vend_valid), 0);
        selectSlot(12);
        chk("range sel_error", 32'(sel_error), 1);
        doCancel();
        for (int k = 0; k < 8; k++) takeCoin(2, int'($urandom_range(3, 0)), "refund200");
        chk("refund200 busy", 32'(busy), 0);
        chk("refund200 credit", 32'(credit), 0);

        // 40c change, coin during CHANGE, reset mid-payout
        insertCoin(4);
        chk("can_buy at 100 again", 32'(can_buy), 'h008);
        selectSlot(3);
        chk("vend3 idx", 32'(vend_idx), 3);
        chk("vend3 disp", 32'(disp_value), 40);
        insertCoin(2);
        chk("reject in CHANGE", 32'(coin_reject), 1);
        chk("credit in CHANGE", 32'(credit), 0);
        takeCoin(2, 1, "chg40 first");
        chk("chg40 disp 15", 32'(disp_value), 15);
        takeCoin(1, 0, "chg40 second");
        chk("third coin pending", 32'(coin_out_valid), 1);
        chk("third coin type", 32'(coin_out_type), 0);
        reset = 1'b1;
        #1;
        chk("midrst valid", 32'(coin_out_valid), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst disp", 32'(disp_value), 0);
        chk("midrst oos", 32'(oos), 'h1FF);
        chk("midrst can_buy", 32'(can_buy), 0);
        coin_out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post-reset no coin", 32'(coin_out_valid), 0);
        end
        coin_out_ready = 1'b0;

        // Same-cycle cancel + select + coin
        cfg(0, 100, 5);
        chk("recfg oos", 32'(oos), 'h1FE);
        insertCoin(4);
        cancel = 1'b1;
        sel_valid = 1'b1;
        sel_idx = '0;
        coin_valid = 1'b1;
        coin_sel = 3'd2;
        tick();
        cancel = 1'b0;
        sel_valid = 1'b0;
        coin_valid = 1'b0;
        chk("prio coin rejected", 32'(coin_reject), 1);
        chk("prio no vend", 32'(vend_valid), 0);
        chk("prio no sel_error", 32'(sel_error), 0);
        chk("prio credit", 32'(credit), 0);
        chk("prio busy", 32'(busy), 1);
        chk("prio disp", 32'(disp_value), 100);
        for (int k = 0; k < 4; k++) takeCoin(2, k % 2, "prio refund");
        chk("prio done busy", 32'(busy), 0);
        chk("prio stock kept", 32'(oos), 'h1FE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
